// File: rtl/mandelbrot_recirc.sv
// mandelbrot_recirc: ring controller for the fractal pixel pipeline.
// Seeds the math input FIFO with one frame of zeroed records, then recirculates
// every record from the math output FIFO back into the input FIFO while
// presenting its pixel value on a one-deep ready/valid stream. The draw mode
// is only latched at frame boundaries so the math block never switches
// mode in the middle of a frame.
module mandelbrot_recirc #(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 480
) (
    input  logic         i_Clk,
    input  logic         i_Reset,
    input  logic [103:0] i_Out_Fifo_Data,
    input  logic         i_Out_Fifo_Empty,
    output logic         o_Out_Fifo_Rdreq,
    output logic [103:0] o_In_Fifo_Data,
    output logic         o_In_Fifo_Wrreq,
    input  logic         i_In_Fifo_Full,
    output logic [7:0]   o_Px_Val,
    output logic         o_Px_Valid,
    output logic         o_Px_Sof,
    input  logic         i_Px_Ready,
    input  logic [1:0]   i_Draw,
    output logic [1:0]   o_Draw,
    output logic [15:0]  o_Frame_Count,
    output logic         o_Filled
);

    // state     | meaning
    // ST_FILL   | seeding the input FIFO with WIDTH*HEIGHT zeroed records
    // ST_RUN    | recirculating records and streaming pixel values

    // Encoding of the clear mode from draw.vh; other modes pass through untouched.
    localparam logic [1:0] DRAW_CLEAR = 2'd0;

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int XW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [18:0]   FILL_LAST = 19'(NPIX - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [18:0]   fill_cnt;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          fill_wr;
    logic          fill_done;
    logic          xfer;
    logic          x_last;
    logic          y_last;
    logic          frame_end;

    assign x_last    = (x == X_LAST);
    assign y_last    = (y == Y_LAST);
    assign frame_end = xfer & x_last & y_last;

    // Next-state and transfer decision; reset masks every FIFO strobe so a
    // reset cycle can never pop or write a record.
    always_comb begin
        state_next = state;
        fill_wr    = 1'b0;
        fill_done  = 1'b0;
        xfer       = 1'b0;
        case (state)
            ST_FILL: begin
                fill_wr   = ~i_In_Fifo_Full & ~i_Reset;
                fill_done = fill_wr & (fill_cnt == FILL_LAST);
                if (fill_done) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                xfer = ~i_Out_Fifo_Empty & ~i_In_Fifo_Full
                     & (~o_Px_Valid | i_Px_Ready) & ~i_Reset;
            end
            default: begin
                state_next = ST_FILL;
            end
        endcase
    end

    // The popped record goes straight back into the ring in the same cycle.
    assign o_Out_Fifo_Rdreq = xfer;
    assign o_In_Fifo_Wrreq  = fill_wr | xfer;
    assign o_In_Fifo_Data   = (state == ST_RUN) ? i_Out_Fifo_Data : '0;
    assign o_Filled         = (state == ST_RUN);

    // State register.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Seeding counter: advances only on writes that actually happen.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            fill_cnt <= '0;
        end else if (fill_wr) begin
            fill_cnt <= fill_cnt + 19'd1;
        end
    end

    // Raster position of the next record to leave the math output FIFO.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            x <= '0;
            y <= '0;
        end else if (xfer) begin
            if (x_last) begin
                x <= '0;
                y <= y_last ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // One-deep pixel register: reloads on a transfer, empties when the sink
    // takes the pixel with nothing new behind it, otherwise holds.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Px_Val   <= '0;
            o_Px_Valid <= 1'b0;
            o_Px_Sof   <= 1'b0;
        end else if (xfer) begin
            o_Px_Val   <= i_Out_Fifo_Data[103:96];
            o_Px_Valid <= 1'b1;
            o_Px_Sof   <= (x == '0) && (y == '0);
        end else if (o_Px_Valid & i_Px_Ready) begin
            o_Px_Valid <= 1'b0;
            o_Px_Sof   <= 1'b0;
        end
    end

    // Frame counter and draw-mode latch, updated only at frame boundaries
    // (end of seeding and the transfer of the last pixel of a frame).
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Frame_Count <= '0;
            o_Draw        <= DRAW_CLEAR;
        end else begin
            if (frame_end) begin
                o_Frame_Count <= o_Frame_Count + 16'd1;
            end
            if (frame_end | fill_done) begin
                o_Draw <= i_Draw;
            end
        end
    end

endmodule

// File: tb/tb_mandelbrot_recirc.sv
// Scoreboard bench for mandelbrot_recirc on a 4x2 frame.
module tb_mandelbrot_recirc;

    localparam int W = 4;
    localparam int H = 2;
    localparam logic [1:0] D_CLEAR = 2'd0;
    localparam logic [1:0] D_MAND  = 2'd1;
    localparam logic [1:0] D_JULIA = 2'd2;

    logic         i_Clk = 1'b0;
    logic         i_Reset;
    logic [103:0] i_Out_Fifo_Data;
    logic         i_Out_Fifo_Empty;
    logic         o_Out_Fifo_Rdreq;
    logic [103:0] o_In_Fifo_Data;
    logic         o_In_Fifo_Wrreq;
    logic         i_In_Fifo_Full;
    logic [7:0]   o_Px_Val;
    logic         o_Px_Valid;
    logic         o_Px_Sof;
    logic         i_Px_Ready;
    logic [1:0]   i_Draw;
    logic [1:0]   o_Draw;
    logic [15:0]  o_Frame_Count;
    logic         o_Filled;

    mandelbrot_recirc #(.WIDTH(W), .HEIGHT(H)) dut (
        .i_Clk(i_Clk),
        .i_Reset(i_Reset),
        .i_Out_Fifo_Data(i_Out_Fifo_Data),
        .i_Out_Fifo_Empty(i_Out_Fifo_Empty),
        .o_Out_Fifo_Rdreq(o_Out_Fifo_Rdreq),
        .o_In_Fifo_Data(o_In_Fifo_Data),
        .o_In_Fifo_Wrreq(o_In_Fifo_Wrreq),
        .i_In_Fifo_Full(i_In_Fifo_Full),
        .o_Px_Val(o_Px_Val),
        .o_Px_Valid(o_Px_Valid),
        .o_Px_Sof(o_Px_Sof),
        .i_Px_Ready(i_Px_Ready),
        .i_Draw(i_Draw),
        .o_Draw(o_Draw),
        .o_Frame_Count(o_Frame_Count),
        .o_Filled(o_Filled)
    );

    always #5 i_Clk = ~i_Clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [103:0] ofifo[$];
    logic [103:0] exp_wr[$];
    logic [8:0]   exp_px[$];
    logic         pop_pending = 1'b0;

    task automatic chk(input string name, input logic [103:0] act, input logic [103:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void refresh();
        i_Out_Fifo_Empty = (ofifo.size() == 0);
        i_Out_Fifo_Data  = (ofifo.size() != 0) ? ofifo[0] : '0;
    endfunction

    task automatic tick();
        @(posedge i_Clk);
        if (pop_pending && ofifo.size() != 0) void'(ofifo.pop_front());
        #1;
        refresh();
    endtask

    task automatic push_rec(input logic [7:0] pv, input logic sof);
        logic [103:0] rec;
        rec = {pv, 32'h1000_0000 + 32'(pv), 32'h2000_0000 + 32'(pv), 32'hC0DE_0000 ^ {pv, pv, pv, pv}};
        ofifo.push_back(rec);
        exp_wr.push_back(rec);
        exp_px.push_back({sof, pv});
        refresh();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_px.size() != 0 || exp_wr.size() != 0 || ofifo.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        chk("drain_left", 104'(exp_px.size() + exp_wr.size() + ofifo.size()), 104'd0);
    endtask

    // Releases reset (called with i_Reset high) and walks through seeding.
    task automatic do_fill(input int stall, input logic [1:0] draw_exp);
        for (int i = 0; i < W * H; i++) exp_wr.push_back('0);
        i_In_Fifo_Full = (stall > 0);
        i_Reset = 1'b0;
        for (int i = 0; i < stall; i++) begin
            #1;
            chk("fill_full_wrreq", 104'(o_In_Fifo_Wrreq), 104'd0);
            tick();
        end
        i_In_Fifo_Full = 1'b0;
        for (int i = 0; i < W * H; i++) begin
            #1;
            chk("fill_wrreq", 104'(o_In_Fifo_Wrreq), 104'd1);
            chk("fill_rdreq", 104'(o_Out_Fifo_Rdreq), 104'd0);
            chk("fill_filled", 104'(o_Filled), 104'd0);
            tick();
        end
        #1;
        chk("filled_rise", 104'(o_Filled), 104'd1);
        chk("fill_draw", 104'(o_Draw), 104'(draw_exp));
        chk("fill_writes_left", 104'(exp_wr.size()), 104'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_px_valid", 104'(o_Px_Valid), 104'd0);
        chk("rst_px_val", 104'(o_Px_Val), 104'd0);
        chk("rst_px_sof", 104'(o_Px_Sof), 104'd0);
        chk("rst_frame_count", 104'(o_Frame_Count), 104'd0);
        chk("rst_filled", 104'(o_Filled), 104'd0);
        chk("rst_draw", 104'(o_Draw), 104'(D_CLEAR));
        chk("rst_rdreq", 104'(o_Out_Fifo_Rdreq), 104'd0);
        chk("rst_wrreq", 104'(o_In_Fifo_Wrreq), 104'd0);
    endtask

    // Monitor: compares every FIFO write and every accepted pixel against the scoreboard.
    initial begin
        forever begin
            @(negedge i_Clk);
            if (i_Reset !== 1'b1) begin
                if (o_In_Fifo_Wrreq) begin
                    if (exp_wr.size() == 0) chk("wr_unexpected", 104'd1, 104'd0);
                    else chk("in_fifo_data", o_In_Fifo_Data, exp_wr.pop_front());
                end
                if (o_Px_Valid && i_Px_Ready) begin
                    if (exp_px.size() == 0) chk("px_unexpected", 104'd1, 104'd0);
                    else chk("px_sof_val", 104'({o_Px_Sof, o_Px_Val}), 104'(exp_px.pop_front()));
                end
                if (o_Out_Fifo_Rdreq && !o_In_Fifo_Wrreq) chk("pop_without_write", 104'd1, 104'd0);
            end
            pop_pending = o_Out_Fifo_Rdreq;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_Reset = 1'b1;
        i_In_Fifo_Full = 1'b0;
        i_Px_Ready = 1'b1;
        i_Draw = D_MAND;
        refresh();
        tick();
        tick();
        chk_reset_vals();

        // Seeding
        do_fill(0, D_MAND);

        // Pass-through, one full frame
        for (int i = 0; i < 8; i++) push_rec(8'(8'h10 + i), i == 0);
        drain();
        chk("frame_count_1", 104'(o_Frame_Count), 104'd1);
        chk("draw_hold_mand", 104'(o_Draw), 104'(D_MAND));

        // Sink stall
        i_Px_Ready = 1'b0;
        push_rec(8'h20, 1'b1);
        push_rec(8'h21, 1'b0);
        push_rec(8'h22, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_rdreq", 104'(o_Out_Fifo_Rdreq), 104'd0);
            chk("stall_valid", 104'(o_Px_Valid), 104'd1);
            chk("stall_val", 104'(o_Px_Val), 104'h20);
            tick();
        end
        i_Px_Ready = 1'b1;
        #1;
        chk("resume_rdreq", 104'(o_Out_Fifo_Rdreq), 104'd1);
        drain();

        // Input FIFO full in RUN; frame position is now 3
        for (int k = 0; k < 16; k++) push_rec(8'(8'h30 + k), (k == 5) || (k == 13));
        tick();
        tick();
        i_In_Fifo_Full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("full_rdreq", 104'(o_Out_Fifo_Rdreq), 104'd0);
            chk("full_wrreq", 104'(o_In_Fifo_Wrreq), 104'd0);
            tick();
        end
        i_In_Fifo_Full = 1'b0;
        drain();
        chk("frame_count_3", 104'(o_Frame_Count), 104'd3);

        // Draw latch: change mid-frame at position 3, five transfers to frame end
        i_Draw = D_JULIA;
        for (int k = 0; k < 5; k++) push_rec(8'(8'h40 + k), 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("draw_rdreq", 104'(o_Out_Fifo_Rdreq), 104'd1);
            chk("draw_still_mand", 104'(o_Draw), 104'(D_MAND));
            tick();
        end
        #1;
        chk("draw_julia", 104'(o_Draw), 104'(D_JULIA));
        chk("frame_count_4", 104'(o_Frame_Count), 104'd4);
        drain();

        // Reset at pixel (2,1)
        for (int k = 0; k < 6; k++) push_rec(8'(8'h50 + k), k == 0);
        drain();
        i_Px_Ready = 1'b0;
        push_rec(8'h56, 1'b0);
        tick();
        #1;
        chk("pre_rst_valid", 104'(o_Px_Valid), 104'd1);
        chk("pre_rst_val", 104'(o_Px_Val), 104'h56);
        exp_px.delete();
        exp_wr.delete();
        push_rec(8'h57, 1'b0);
        exp_px.delete();
        exp_wr.delete();
        i_Px_Ready = 1'b1;
        i_Reset = 1'b1;
        #1;
        chk("rst_force_rdreq", 104'(o_Out_Fifo_Rdreq), 104'd0);
        chk("rst_force_wrreq", 104'(o_In_Fifo_Wrreq), 104'd0);
        tick();
        ofifo.delete();
        refresh();
        #1;
        chk_reset_vals();
        do_fill(2, D_JULIA);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mandelbrot_recirc.md
# mandelbrot_recirc

Ring controller for the fractal pixel pipeline. After reset it seeds the math input FIFO with one frame of zeroed 104-bit pixel records. It then drains the math output FIFO in raster order, pushes each record back into the input FIFO, and presents the 8-bit pixel value on a ready/valid stream toward the LCD frame writer. It also latches the draw mode at frame boundaries, so `mandelbrot_math` never changes mode mid-frame.

## Interface
Parameters:
- `WIDTH`, 800: pixels per line.
- `HEIGHT`, 480: lines per frame.

Ports:
- `i_Clk` in 1: single clock for the whole block.
- `i_Reset` in 1: reset, synchronous, active-high.
- `i_Out_Fifo_Data` in 104: show-ahead head of the math output FIFO, as {PxVal[7:0], X[31:0], Y[31:0], Iter[31:0]}.
- `i_Out_Fifo_Empty` in 1: math output FIFO empty.
- `o_Out_Fifo_Rdreq` out 1: pop the math output FIFO (combinational).
- `o_In_Fifo_Data` out 104: record written to the math input FIFO.
- `o_In_Fifo_Wrreq` out 1: write strobe for the math input FIFO (combinational).
- `i_In_Fifo_Full` in 1: math input FIFO full.
- `o_Px_Val` out 8: pixel value toward the LCD frame writer.
- `o_Px_Valid` out 1: `o_Px_Val` holds a pixel.
- `o_Px_Sof` out 1: current pixel is (0,0) of a frame.
- `i_Px_Ready` in 1: sink accepts the pixel this cycle.
- `i_Draw` in 2: requested draw mode, encoded per `draw.vh`.
- `o_Draw` out 2: draw mode applied by `mandelbrot_math`.
- `o_Frame_Count` out 16: completed frames since reset; wraps modulo 2^16.
- `o_Filled` out 1: high once the seeding phase is done.

## Operation
- Two states: FILL (reset state) and RUN.
- FILL:
  - `o_In_Fifo_Wrreq = ~i_In_Fifo_Full`, with `o_In_Fifo_Data = 104'h0`.
  - `fill_cnt` (19 bits) increments on each write.
  - The write with `fill_cnt == WIDTH*HEIGHT-1` moves the state to RUN on the next cycle and latches `o_Draw <= i_Draw`.
  - `o_Out_Fifo_Rdreq = 0`. The pixel stream stays idle.
- RUN, per-cycle transfer:
  - `xfer = ~i_Out_Fifo_Empty & ~i_In_Fifo_Full & (~o_Px_Valid | i_Px_Ready)`.
  - `o_Out_Fifo_Rdreq = o_In_Fifo_Wrreq = xfer`.
  - `o_In_Fifo_Data = i_Out_Fifo_Data`, passed through unmodified.
- On each `xfer`:
  - `o_Px_Val <= i_Out_Fifo_Data[103:96]` and `o_Px_Valid <= 1`.
  - `o_Px_Sof <= (x==0 && y==0)`.
  - Advance `x`/`y`: `x` wraps at `WIDTH-1` to 0 and increments `y`; `y` wraps at `HEIGHT-1` to 0.
- If `o_Px_Valid & i_Px_Ready & ~xfer`: `o_Px_Valid <= 0` and `o_Px_Sof <= 0`.
- Frame end is the `xfer` of pixel (`WIDTH-1`, `HEIGHT-1`). On that cycle:
  - `o_Frame_Count` increments.
  - `o_Draw <= i_Draw` (latched here and at FILL exit only).
- `i_Draw` changes mid-frame have no effect until the next frame end.
- The record count in the ring is invariant at `WIDTH*HEIGHT`. The raster counters therefore stay aligned with the math block's internal `px_x`/`px_y`.
- `o_Filled = (state == RUN)`.

## Timing
- Reset values:
  - State FILL; `fill_cnt`, `x`, `y` = 0.
  - `o_Px_Val = 0`, `o_Px_Valid = 0`, `o_Px_Sof = 0`, `o_Frame_Count = 0`, `o_Filled = 0`.
  - `o_Draw = DRAW_CLEAR`.
  - `o_Out_Fifo_Rdreq` and `o_In_Fifo_Wrreq` are forced 0 while `i_Reset` is high.
- Latency:
  - FIFO side: zero cycles. The record is popped and written in the same cycle.
  - Pixel side: one cycle from pop to `o_Px_Valid`.
- Pixel stream is a one-deep register:
  - `o_Px_Val` and `o_Px_Sof` hold stable while `o_Px_Valid & ~i_Px_Ready`.
  - A new pixel may load in the same cycle the old one is accepted, giving full throughput of 1 pixel/cycle.
- Backpressure:
  - Any of out-empty, in-full, or stalled pixel sink blocks `xfer`.
  - No record is ever popped without being written back.
- Reset mid-operation: state, counters and outputs return to reset values on the next edge. Flushing the FIFOs is the top level's job; it asserts the FIFO `sclr` with `i_Reset`.
- FILL with `i_In_Fifo_Full` high: the counter holds and no write is issued.

## Test plan
- Seeding (`WIDTH`=4, `HEIGHT`=2, input FIFO never full):
  - Reset, then release -> exactly 8 writes of `104'h0` on cycles 1..8.
  - `o_Filled` rises on cycle 9. `o_Out_Fifo_Rdreq` stays 0 throughout FILL.
- Pass-through:
  - Feed records with PxVal 0x10..0x17, sink always ready -> `o_In_Fifo_Data` matches each input bit-for-bit.
  - `o_Px_Val` = 0x10..0x17 one cycle later. `o_Px_Sof` is high only with 0x10.
  - `o_Frame_Count` = 1 after the 8th transfer.
- Sink stall:
  - Hold `i_Px_Ready` low for 3 cycles with data pending -> no pops.
  - `o_Px_Val` stays stable. Transfers resume the cycle `i_Px_Ready` returns high.
- Input full:
  - Assert `i_In_Fifo_Full` for 2 cycles in RUN -> `o_Out_Fifo_Rdreq` = 0 on those cycles.
  - No pixel is lost or duplicated; check 16-pixel ordering.
- Draw latch:
  - Change `i_Draw` from MANDELBROT to JULIA mid-frame -> `o_Draw` changes only on the cycle after the frame-end transfer.
- Reset mid-RUN:
  - Assert `i_Reset` at pixel (2,1) -> all outputs return to reset values.
  - FILL restarts and issues 8 writes.
